aes_inv_key_schedule: RTL

Round-key generator for the AES-128 decryption datapath. Takes the 128-bit cipher key, expands it forward to the round-10 key, then walks the schedule backwards and delivers round keys 10, 9, …, 0, one per valid/ready transfer. It is the counterpart of the forward key expansion used by the encryption path and sits between the key register and the inverse-cipher round logic.

---
 rtl/aes_pkg.sv | 34 +++
 rtl/aes_sbox.sv | 34 +++
 rtl/aes_inv_key_schedule.sv | 109 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the inverse key schedule.
// Contents: FSM state enum, byte/word typedefs, the round-constant table
// (rounds 1..10) and small word-level helpers.
package aes_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2
    } state_t;

    localparam byte_t RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round constant as a word; any round outside 1..10 yields zero.
    function automatic word_t rcon_word(input logic [3:0] round);
        word_t w;
        w = '0;
        if (round inside {[4'd1:4'd10]})
            w[31:24] = RCON[round];
        return w;
    endfunction

    // {b0,b1,b2,b3} -> {b1,b2,b3,b0}
    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte.
// Ports: val - input byte, sub - substituted byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] val,
    output logic [7:0] sub
);

    // Entry 0 is the most significant byte, so SBOX[val] reads directly.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    byte_t result;
    assign result = SBOX[val];
    assign sub    = result;

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule. Expands the cipher key forward to round 10,
// then walks back and hands out round keys 10..0 over a valid/ready port.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   start, key_in   - start request and cipher key (sampled in IDLE only)
//   busy            - schedule in progress (FWD or REV)
//   rk_valid/ready  - round-key handshake
//   rk, rk_round    - current round key and its round index
//   rk_last         - current key is round 0
module aes_inv_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         rk_last
);

    state_t       state;
    logic [127:0] key_reg;
    logic [3:0]   cnt;

    word_t k0, k1, k2, k3;
    word_t sub_in, sub_rot, sub_out, rc;
    word_t n0, n1, n2, n3;
    word_t p0, p1, p2, p3;

    assign {k0, k1, k2, k3} = key_reg;

    // A single SubWord serves both directions: forward needs k3, the
    // inverse step needs the recovered previous word3, which is k3^k2.
    assign p3      = k3 ^ k2;
    assign sub_in  = (state == REV) ? p3 : k3;
    assign sub_rot = rot_word(sub_in);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .val (sub_rot[8*g +: 8]),
            .sub (sub_out[8*g +: 8])
        );
    end

    // Forward builds round cnt+1; reverse undoes round cnt.
    assign rc = rcon_word((state == FWD) ? cnt + 4'd1 : cnt);

    assign n0 = k0 ^ sub_out ^ rc;
    assign n1 = k1 ^ n0;
    assign n2 = k2 ^ n1;
    assign n3 = k3 ^ n2;

    assign p2 = k2 ^ k1;
    assign p1 = k1 ^ k0;
    assign p0 = k0 ^ sub_out ^ rc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            key_reg <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        key_reg <= key_in;
                        cnt     <= '0;
                        state   <= FWD;
                    end
                end
                FWD: begin
                    key_reg <= {n0, n1, n2, n3};
                    if (cnt == 4'd9) begin
                        cnt   <= 4'd10;
                        state <= REV;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                REV: begin
                    // rk_valid is high throughout REV, so rk_ready alone
                    // marks a transfer here.
                    if (rk_ready) begin
                        if (cnt != 4'd0) begin
                            key_reg <= {p0, p1, p2, p3};
                            cnt     <= cnt - 4'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from registered state only; nothing leaks from
    // rk_ready or start.
    assign busy     = (state != IDLE);
    assign rk_valid = (state == REV);
    assign rk       = rk_valid ? key_reg : '0;
    assign rk_round = rk_valid ? cnt : 4'd0;
    assign rk_last  = rk_valid && (cnt == 4'd0);

endmodule
